branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised next-generation branch controller for the pipelined RV32I core. It keeps a direct-mapped branch target buffer (BTB) with 2-bit bimodal counters and supplies a fetch-stage prediction.
- It resolves branches in execute using the full RV32I condition set and issues a registered one-cycle redirect/flush on a misprediction.
- It also maintains branch and mispredict performance counters.

Parameters:
- XLEN, 32, datapath width. PCW = XLEN-2 (word-addressed PC).
- ENTRIES, 16, BTB entries. Must be a power of 2, minimum 2. IDX = log2(ENTRIES).
- TAG_W, 8, tag bits per entry. IDX+TAG_W <= PCW.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- f_valid  in  1  fetch lookup valid
- f_pc  in  PCW  fetch word address
- f_pred_taken  out  1  predicted taken (combinational)
- f_pred_addr  out  PCW  predicted target (combinational)
- x_valid  in  1  resolve valid
- x_mode  in  2  00 disable, 01 jmp, 10 cmp, 11 alu-target jump
- x_cond  in  3  funct3 of the branch
- x_pc  in  PCW  branch word address
- x_rs1, x_rs2  in  XLEN  compare operands
- x_imm  in  XLEN  sign-extended byte offset
- x_alu  in  XLEN  JALR target (byte address)
- x_pred_taken  in  1  prediction carried down the pipe from fetch
- x_pred_addr  in  PCW  predicted target carried down the pipe
- redirect  out  1  registered one-cycle pulse
- redirect_addr  out  PCW  corrected fetch address
- flush  out  1  equals redirect; kills younger instructions
- branch_cnt  out  CNT_W  resolved mode!=00 count
- mispredict_cnt  out  CNT_W  mispredict count

Behaviour:
- Reset, asynchronous and applied immediately:
  - All BTB valid bits clear.
  - redirect, flush, redirect_addr, branch_cnt and mispredict_cnt are 0.
  - Counter and target RAM contents are don't-care.
- Lookup is combinational:
  - idx = f_pc[IDX-1:0]; tag = f_pc[IDX+TAG_W-1:IDX].
  - hit = f_valid & valid[idx] & tag match.
  - f_pred_taken = hit & ctr[idx][1].
  - f_pred_addr = hit ? target[idx] : f_pc+1 (wraps modulo 2^PCW).
- Actual outcome, when x_valid:
  - Mode 00: not taken.
  - Modes 01 and 11: taken.
  - Mode 10, by x_cond: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010 and 011 are not taken.
- Actual target:
  - Modes 01/10: x_pc + (x_imm >>> 2), arithmetic shift, modulo 2^PCW.
  - Mode 11: x_alu[XLEN-1:2]. Bits [1:0] are ignored.
- Mispredict when either holds:
  - actual_taken != x_pred_taken.
  - Both taken and target != x_pred_addr.
- Redirect path:
  - On the next rising edge, redirect = flush = 1 and redirect_addr = actual_taken ? target : x_pc+1.
  - Held for exactly one cycle, then 0.
  - Latency from resolve to redirect is 1 cycle.
  - Back-to-back mispredicts give consecutive pulses.
  - redirect_addr holds its last value when redirect = 0.
- BTB update, registered at the same edge, using x_pc idx/tag:
  - Resolve-hit, mode != 00: the counter saturates. Taken increments, capped at 11. Not-taken decrements, floored at 00. When taken, target is written.
  - Resolve-miss, taken: allocate by setting valid, tag and target. ctr = 11 for modes 01/11, 10 for mode 10. The old entry is overwritten.
  - Resolve-miss, not taken: no change.
  - Mode 00 with a hit (alias on a non-branch): clear valid.
  - x_valid = 0: no update, no counting.
- Simultaneous lookup and update of the same idx: lookup returns the pre-update contents, read-before-write.
- Counters:
  - branch_cnt increments on x_valid & mode != 00.
  - mispredict_cnt increments on every mispredict.
  - Both wrap at 2^CNT_W.
- Reset asserted mid-pulse clears redirect immediately. The first lookup after reset release misses.

Test Plan:
- Cold BNE: x_pc=0x40, imm=-16, rs1=1, rs2=2, pred 0 -> next cycle redirect=1, redirect_addr=0x3C, entry allocated with ctr=10. Then f_pc=0x40 -> f_pred_taken=1, f_pred_addr=0x3C.
- Loop trains: same BNE taken 3x then not-taken -> ctr reaches 11. Not-taken resolve with pred 1 gives redirect to 0x41 and ctr 10; following lookup still predicts taken.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1 -> BLT (100) taken, BLTU (110) not taken. x_cond=010 -> not taken.
- JALR target change: mode 11, x_alu=0x1003, pred taken with addr 0x200 -> redirect_addr=0x400 and BTB target updated. x_alu=0x1000 with pred 0x400 -> no redirect.
- Alias and same-index: ENTRIES=16, entry at 0x10, mode 00 at 0x10 pred taken -> redirect to 0x11, valid cleared. Lookup of 0x10 in the same cycle as the update still hits; the next cycle misses.
- Reset while redirect=1: redirect drops asynchronously, counters read 0, all lookups miss. Counter wrap checked with CNT_W=4 after 16 branches -> branch_cnt=0.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, execute-resolve and redirect/perf-counter signals of the branch predictor.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  localparam int PCW = XLEN - 2;

  logic             f_valid;
  logic [PCW-1:0]   f_pc;
  logic             f_pred_taken;
  logic [PCW-1:0]   f_pred_addr;
  logic             x_valid;
  logic [1:0]       x_mode;
  logic [2:0]       x_cond;
  logic [PCW-1:0]   x_pc;
  logic [XLEN-1:0]  x_rs1;
  logic [XLEN-1:0]  x_rs2;
  logic [XLEN-1:0]  x_imm;
  logic [XLEN-1:0]  x_alu;
  logic             x_pred_taken;
  logic [PCW-1:0]   x_pred_addr;
  logic             redirect;
  logic [PCW-1:0]   redirect_addr;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output f_valid, f_pc, x_valid, x_mode, x_cond, x_pc, x_rs1, x_rs2, x_imm, x_alu,
           x_pred_taken, x_pred_addr,
    input  f_pred_taken, f_pred_addr, redirect, redirect_addr, flush, branch_cnt,
           mispredict_cnt
  );

  modport slave (
    input  f_valid, f_pc, x_valid, x_mode, x_cond, x_pc, x_rs1, x_rs2, x_imm, x_alu,
           x_pred_taken, x_pred_addr,
    output f_pred_taken, f_pred_addr, redirect, redirect_addr, flush, branch_cnt,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit bimodal counters, execute-stage branch resolution,
// registered redirect/flush on mispredict and branch/mispredict counters.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int PCW = XLEN - 2;
  localparam int IDX = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PCW-1:0]     tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic             redirect_q;
  logic [PCW-1:0]   redirect_addr_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  // Fetch lookup reads the arrays before this cycle's update lands.
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = bus.f_pc[IDX-1:0];
  assign f_tag = bus.f_pc[IDX+TAG_W-1:IDX];
  assign f_hit = bus.f_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);

  assign bus.f_pred_taken = f_hit & ctr_q[f_idx][1];
  assign bus.f_pred_addr  = f_hit ? tgt_q[f_idx] : bus.f_pc + PCW'(1);

  logic [IDX-1:0]   x_idx;
  logic [TAG_W-1:0] x_tag;
  logic             x_hit;
  logic             x_taken;
  logic             x_go;
  logic             x_mis;
  logic             x_br;
  logic [XLEN-1:0]  imm_sh;
  logic [PCW-1:0]   x_tgt;
  logic [PCW-1:0]   x_seq;
  logic [1:0]       ctr_nxt;

  assign x_idx  = bus.x_pc[IDX-1:0];
  assign x_tag  = bus.x_pc[IDX+TAG_W-1:IDX];
  assign x_hit  = valid_q[x_idx] & (tag_q[x_idx] == x_tag);
  assign imm_sh = $signed(bus.x_imm) >>> 2;
  assign x_tgt  = (bus.x_mode == 2'b11) ? bus.x_alu[XLEN-1:2] : bus.x_pc + imm_sh[PCW-1:0];
  assign x_seq  = bus.x_pc + PCW'(1);

  always_comb begin
    x_taken = 1'b0;
    case (bus.x_mode)
      2'b01, 2'b11: x_taken = 1'b1;
      2'b10: begin
        case (bus.x_cond)
          3'b000:  x_taken = (bus.x_rs1 == bus.x_rs2);
          3'b001:  x_taken = (bus.x_rs1 != bus.x_rs2);
          3'b100:  x_taken = ($signed(bus.x_rs1) <  $signed(bus.x_rs2));
          3'b101:  x_taken = ($signed(bus.x_rs1) >= $signed(bus.x_rs2));
          3'b110:  x_taken = (bus.x_rs1 <  bus.x_rs2);
          3'b111:  x_taken = (bus.x_rs1 >= bus.x_rs2);
          default: x_taken = 1'b0;
        endcase
      end
      default: x_taken = 1'b0;
    endcase
  end

  // Target only matters when both sides agree the branch was taken.
  assign x_go  = bus.x_valid & x_taken;
  assign x_br  = bus.x_valid & (bus.x_mode != 2'b00);
  assign x_mis = bus.x_valid & ((x_taken != bus.x_pred_taken) |
                                (x_taken & bus.x_pred_taken & (x_tgt != bus.x_pred_addr)));

  always_comb begin
    ctr_nxt = ctr_q[x_idx];
    if (x_taken) begin
      if (ctr_q[x_idx] != 2'b11) ctr_nxt = ctr_q[x_idx] + 2'b01;
    end else begin
      if (ctr_q[x_idx] != 2'b00) ctr_nxt = ctr_q[x_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= '0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      branch_cnt_q    <= '0;
      mis_cnt_q       <= '0;
    end else begin
      redirect_q <= x_mis;
      if (x_mis) begin
        redirect_addr_q <= x_taken ? x_tgt : x_seq;
        mis_cnt_q       <= mis_cnt_q + CNT_W'(1);
      end
      if (x_br) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (bus.x_valid) begin
        // A non-branch that hit is an alias; drop the entry so it stops predicting.
        if (bus.x_mode == 2'b00 && x_hit) valid_q[x_idx] <= 1'b0;
        else if (!x_hit && x_taken)       valid_q[x_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (x_go) tgt_q[x_idx] <= x_tgt;
    if (x_go && !x_hit) begin
      tag_q[x_idx] <= x_tag;
      ctr_q[x_idx] <= (bus.x_mode == 2'b10) ? 2'b10 : 2'b11;
    end else if (bus.x_valid && x_hit && bus.x_mode != 2'b00) begin
      ctr_q[x_idx] <= ctr_nxt;
    end
  end

  assign bus.redirect       = redirect_q;
  assign bus.flush          = redirect_q;
  assign bus.redirect_addr  = redirect_addr_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mis_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{bus.f_pc, bus.x_pc, bus.x_alu, imm_sh};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised and directed checks of branch_predict_unit against a table-level BTB model.
module tb_branch_predict_unit;
  localparam int XLEN = 32, ENTRIES = 16, TAG_W = 8, CNT_W = 4, PCW = XLEN - 2;
  localparam longint PCM = (64'sd1 <<< PCW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: one record per BTB slot, counters as plain integers.
  bit     m_valid [ENTRIES];
  longint m_tag   [ENTRIES];
  longint m_tgt   [ENTRIES];
  int     m_ctr   [ENTRIES];
  longint m_bcnt, m_mcnt, m_raddr;
  bit     m_redir;
  bit     e_pt;
  longint e_pa;
  logic           a_pt;
  logic [PCW-1:0] a_pa;
  logic [31:0] ops [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7};

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_bcnt = 0; m_mcnt = 0; m_raddr = 0; m_redir = 1'b0;
  endfunction

  function automatic void model_lookup(input bit v, input longint pc);
    int i = int'(pc % ENTRIES);
    bit hit = v && m_valid[i] && (m_tag[i] == (pc / ENTRIES) % (1 << TAG_W));
    e_pt = hit && (m_ctr[i] >= 2);
    e_pa = hit ? m_tgt[i] : (pc + 1) & PCM;
  endfunction

  function automatic void model_resolve();
    longint pc  = {34'h0, bus.x_pc};
    longint ppa = {34'h0, bus.x_pred_addr};
    longint ua  = {32'h0, bus.x_rs1};
    longint ub  = {32'h0, bus.x_rs2};
    longint sa  = int'(bus.x_rs1);
    longint sb  = int'(bus.x_rs2);
    longint imm = int'(bus.x_imm);
    longint tgt, tag, off;
    int idx;
    bit tk, hit, mis;
    m_redir = 1'b0;
    if (!bus.x_valid) return;
    case (bus.x_mode)
      2'd0: tk = 1'b0;
      2'd2: case (bus.x_cond)
              3'd0: tk = (ua == ub);
              3'd1: tk = (ua != ub);
              3'd4: tk = (sa < sb);
              3'd5: tk = (sa >= sb);
              3'd6: tk = (ua < ub);
              3'd7: tk = (ua >= ub);
              default: tk = 1'b0;
            endcase
      default: tk = 1'b1;
    endcase
    if (bus.x_mode == 2'd3) tgt = {32'h0, bus.x_alu} / 4;
    else begin
      off = (imm >= 0) ? imm / 4 : -((-imm + 3) / 4);
      tgt = (pc + off) & PCM;
    end
    mis = (tk != bus.x_pred_taken) || (tk && bus.x_pred_taken && tgt != ppa);
    if (bus.x_mode != 2'd0) m_bcnt = (m_bcnt + 1) % (1 << CNT_W);
    if (mis) begin
      m_mcnt  = (m_mcnt + 1) % (1 << CNT_W);
      m_raddr = tk ? tgt : (pc + 1) & PCM;
    end
    m_redir = mis;
    idx = int'(pc % ENTRIES);
    tag = (pc / ENTRIES) % (1 << TAG_W);
    hit = m_valid[idx] && m_tag[idx] == tag;
    if (hit && bus.x_mode != 2'd0) begin
      m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3) : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      if (tk) m_tgt[idx] = tgt;
    end else if (!hit && tk) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = tgt;
      m_ctr[idx] = (bus.x_mode == 2'd2) ? 2 : 3;
    end else if (hit && bus.x_mode == 2'd0) begin
      m_valid[idx] = 1'b0;
    end
  endfunction

  task automatic idle();
    bus.x_valid = 1'b0; bus.f_valid = 1'b0; bus.x_mode = 2'b00; bus.x_cond = 3'b000;
    bus.x_pc = '0; bus.x_rs1 = '0; bus.x_rs2 = '0; bus.x_imm = '0; bus.x_alu = '0;
    bus.x_pred_taken = 1'b0; bus.x_pred_addr = '0; bus.f_pc = '0;
  endtask

  task automatic drive_x(input logic [1:0] mode, input logic [2:0] cond, input longint pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] alu, input bit pt, input longint pa);
    bus.x_valid = 1'b1; bus.x_mode = mode; bus.x_cond = cond; bus.x_pc = PCW'(pc);
    bus.x_rs1 = rs1; bus.x_rs2 = rs2; bus.x_imm = imm; bus.x_alu = alu;
    bus.x_pred_taken = pt; bus.x_pred_addr = PCW'(pa);
  endtask

  task automatic lookup(input longint pc);
    bus.f_valid = 1'b1; bus.f_pc = PCW'(pc);
  endtask

  // One clock: capture the lookup mid-cycle, advance the model, land just after the edge.
  task automatic cycle_model();
    @(negedge clk);
    model_lookup(bus.f_valid, {34'h0, bus.f_pc});
    a_pt = bus.f_pred_taken; a_pa = bus.f_pred_addr;
    model_resolve();
    @(posedge clk); #1;
  endtask

  function automatic longint rnd_pc();
    longint t, ix;
    case ($urandom_range(0, 3))
      0: t = 0; 1: t = 1; 2: t = 256; default: t = PCM >> 4;
    endcase
    case ($urandom_range(0, 3))
      0: ix = 0; 1: ix = 1; 2: ix = 2; default: ix = 15;
    endcase
    return (ix + ENTRIES * t) & PCM;
  endfunction

  task automatic test_reset();
    idle(); rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0b want 0", bus.redirect); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", bus.flush); end
    checks++; if (bus.redirect_addr !== '0) begin errors++; $display("FAIL rst_raddr got %0h want 0", bus.redirect_addr); end
    checks++; if (bus.branch_cnt !== '0 || bus.mispredict_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
    rst_n = 1'b1;
    lookup(64'h40); cycle_model();
    checks++; if (a_pt !== 1'b0 || a_pa !== PCW'(64'h41)) begin errors++; $display("FAIL rst_lookup got %0b/%0h want 0/41", a_pt, a_pa); end
  endtask

  task automatic test_cold_bne();
    idle(); drive_x(2'b10, 3'b001, 64'h40, 32'd1, 32'd2, -32'sd16, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.flush !== 1'b1) begin errors++; $display("FAIL bne_redirect got %0b/%0b want 1/1", bus.redirect, bus.flush); end
    checks++; if (bus.redirect_addr !== PCW'(64'h3C)) begin errors++; $display("FAIL bne_raddr got %0h want 3c", bus.redirect_addr); end
    checks++; if (bus.branch_cnt !== CNT_W'(m_bcnt) || bus.mispredict_cnt !== CNT_W'(m_mcnt)) begin errors++; $display("FAIL bne_cnt got %0d/%0d want %0d/%0d", bus.branch_cnt, bus.mispredict_cnt, m_bcnt, m_mcnt); end
    idle(); lookup(64'h40); cycle_model();
    checks++; if (a_pt !== 1'b1 || a_pa !== PCW'(64'h3C)) begin errors++; $display("FAIL bne_lookup got %0b/%0h want 1/3c", a_pt, a_pa); end
    checks++; if (bus.redirect !== 1'b0 || bus.redirect_addr !== PCW'(64'h3C)) begin errors++; $display("FAIL bne_pulse got %0b/%0h want 0/3c", bus.redirect, bus.redirect_addr); end
  endtask

  task automatic test_loop_train();
    for (int i = 0; i < 3; i++) begin
      idle(); model_lookup(1'b1, 64'h40);
      drive_x(2'b10, 3'b001, 64'h40, 32'd1, 32'd2, -32'sd16, 32'd0, e_pt, e_pa);
      cycle_model();
      checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL train_taken%0d got %0b want 0", i, bus.redirect); end
    end
    idle(); drive_x(2'b10, 3'b001, 64'h40, 32'd5, 32'd5, -32'sd16, 32'd0, 1'b1, 64'h3C);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h41)) begin errors++; $display("FAIL train_nt got %0b/%0h want 1/41", bus.redirect, bus.redirect_addr); end
    idle(); lookup(64'h40); cycle_model();
    checks++; if (a_pt !== 1'b1 || a_pa !== PCW'(64'h3C)) begin errors++; $display("FAIL train_hyst got %0b/%0h want 1/3c", a_pt, a_pa); end
    idle(); drive_x(2'b10, 3'b001, 64'h40, 32'd5, 32'd5, -32'sd16, 32'd0, 1'b1, 64'h3C);
    cycle_model();
    idle(); lookup(64'h40); cycle_model();
    checks++; if (a_pt !== 1'b0 || a_pa !== PCW'(64'h3C)) begin errors++; $display("FAIL train_weak got %0b/%0h want 0/3c", a_pt, a_pa); end
  endtask

  task automatic test_signed_unsigned();
    idle(); drive_x(2'b10, 3'b100, 64'h101, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h103)) begin errors++; $display("FAIL blt got %0b/%0h want 1/103", bus.redirect, bus.redirect_addr); end
    idle(); drive_x(2'b10, 3'b110, 64'h102, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL bltu got %0b want 0", bus.redirect); end
    idle(); drive_x(2'b10, 3'b010, 64'h103, 32'd3, 32'd3, 32'd8, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL cond010 got %0b want 0", bus.redirect); end
    idle(); drive_x(2'b10, 3'b111, 64'h104, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 1'b1, 64'h106);
    cycle_model();
    checks++; if (bus.redirect !== 1'b0 || bus.mispredict_cnt !== CNT_W'(m_mcnt)) begin errors++; $display("FAIL bgeu got %0b/%0d want 0/%0d", bus.redirect, bus.mispredict_cnt, m_mcnt); end
  endtask

  task automatic test_jalr();
    idle(); drive_x(2'b11, 3'b000, 64'h80, 32'd0, 32'd0, 32'd0, 32'h800, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h200)) begin errors++; $display("FAIL jalr_alloc got %0b/%0h want 1/200", bus.redirect, bus.redirect_addr); end
    idle(); drive_x(2'b11, 3'b000, 64'h80, 32'd0, 32'd0, 32'd0, 32'h1003, 1'b1, 64'h200);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h400)) begin errors++; $display("FAIL jalr_change got %0b/%0h want 1/400", bus.redirect, bus.redirect_addr); end
    idle(); lookup(64'h80); cycle_model();
    checks++; if (a_pt !== 1'b1 || a_pa !== PCW'(64'h400)) begin errors++; $display("FAIL jalr_btb got %0b/%0h want 1/400", a_pt, a_pa); end
    idle(); drive_x(2'b11, 3'b000, 64'h80, 32'd0, 32'd0, 32'd0, 32'h1000, 1'b1, 64'h400);
    cycle_model();
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL jalr_ok got %0b want 0", bus.redirect); end
  endtask

  task automatic test_alias();
    idle(); drive_x(2'b01, 3'b000, 64'h10, 32'd0, 32'd0, 32'h40, 32'd0, 1'b0, 0);
    cycle_model();
    idle(); drive_x(2'b00, 3'b000, 64'h10, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 64'h20);
    lookup(64'h10); cycle_model();
    checks++; if (a_pt !== 1'b1 || a_pa !== PCW'(64'h20)) begin errors++; $display("FAIL alias_rbw got %0b/%0h want 1/20", a_pt, a_pa); end
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h11)) begin errors++; $display("FAIL alias_redirect got %0b/%0h want 1/11", bus.redirect, bus.redirect_addr); end
    idle(); lookup(64'h10); cycle_model();
    checks++; if (a_pt !== 1'b0 || a_pa !== PCW'(64'h11)) begin errors++; $display("FAIL alias_cleared got %0b/%0h want 0/11", a_pt, a_pa); end
  endtask

  task automatic test_back_to_back();
    idle(); drive_x(2'b01, 3'b000, 64'h200, 32'd0, 32'd0, 32'd4, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h201)) begin errors++; $display("FAIL b2b_first got %0b/%0h want 1/201", bus.redirect, bus.redirect_addr); end
    drive_x(2'b01, 3'b000, 64'h300, 32'd0, 32'd0, 32'd8, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== PCW'(64'h302)) begin errors++; $display("FAIL b2b_second got %0b/%0h want 1/302", bus.redirect, bus.redirect_addr); end
    idle(); cycle_model();
    checks++; if (bus.redirect !== 1'b0 || bus.redirect_addr !== PCW'(64'h302)) begin errors++; $display("FAIL b2b_hold got %0b/%0h want 0/302", bus.redirect, bus.redirect_addr); end
  endtask

  task automatic test_counter_wrap();
    idle(); rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      drive_x(2'b01, 3'b000, 64'h20, 32'd0, 32'd0, 32'd4, 32'd0, 1'b0, 0);
      cycle_model();
      if (i == 15) begin
        checks++; if (bus.branch_cnt !== CNT_W'(15)) begin errors++; $display("FAIL cnt_15 got %0d want 15", bus.branch_cnt); end
      end
    end
    checks++; if (bus.branch_cnt !== '0 || bus.mispredict_cnt !== '0) begin errors++; $display("FAIL cnt_wrap got %0d/%0d want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
    idle(); cycle_model();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      longint xp, pa;
      bit pt;
      idle();
      xp = rnd_pc();
      model_lookup(1'b1, xp); pt = e_pt; pa = e_pa;
      if ($urandom_range(0, 3) == 0) pt = !pt;
      if ($urandom_range(0, 7) == 0) pa = $urandom_range(0, 32'h3FFF_FFFF);
      if ($urandom_range(0, 3) != 0)
        drive_x(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), xp,
                ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)],
                32'(int'($urandom_range(0, 511)) - 256), $urandom, pt, pa);
      if ($urandom_range(0, 3) != 0) lookup(($urandom_range(0, 1) == 1) ? xp : rnd_pc());
      cycle_model();
      checks++; if (a_pt !== e_pt || a_pa !== PCW'(e_pa)) begin errors++; $display("FAIL rnd_lookup n=%0d got %0b/%0h want %0b/%0h", n, a_pt, a_pa, e_pt, e_pa); end
      checks++; if (bus.redirect !== m_redir || bus.flush !== m_redir) begin errors++; $display("FAIL rnd_redirect n=%0d got %0b/%0b want %0b", n, bus.redirect, bus.flush, m_redir); end
      checks++; if (bus.redirect_addr !== PCW'(m_raddr)) begin errors++; $display("FAIL rnd_raddr n=%0d got %0h want %0h", n, bus.redirect_addr, m_raddr); end
      checks++; if (bus.branch_cnt !== CNT_W'(m_bcnt) || bus.mispredict_cnt !== CNT_W'(m_mcnt)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, bus.branch_cnt, bus.mispredict_cnt, m_bcnt, m_mcnt); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    idle(); drive_x(2'b01, 3'b000, 64'h20, 32'd0, 32'd0, 32'd4, 32'd0, 1'b0, 0);
    cycle_model();
    checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0b want 1", bus.redirect); end
    idle(); rst_n = 1'b0; model_reset(); #1;
    checks++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL midrst_drop got %0b/%0b want 0/0", bus.redirect, bus.flush); end
    checks++; if (bus.branch_cnt !== '0 || bus.mispredict_cnt !== '0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", bus.branch_cnt, bus.mispredict_cnt); end
    @(posedge clk); #1; rst_n = 1'b1;
    lookup(64'h20); cycle_model();
    checks++; if (a_pt !== 1'b0 || a_pa !== PCW'(64'h21)) begin errors++; $display("FAIL midrst_miss got %0b/%0h want 0/21", a_pt, a_pa); end
  endtask

  initial begin
    test_reset();
    test_cold_bne();
    test_loop_train();
    test_signed_unsigned();
    test_jalr();
    test_alias();
    test_back_to_back();
    test_counter_wrap();
    test_random();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
